// File: rtl/rbz_spi_loader.sv
// Dual-target SPI command loader: shifts 1..64 MSB-first bits out to either the
// register or the vector port over a shared SCLK/MOSI pair.
module rbz_spi_loader #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_target,
  input  logic [6:0]  i_cmd_nbits,
  input  logic [63:0] i_cmd_data,
  input  logic        i_abort,
  output logic        o_reg_csb,
  output logic        o_vec_csb,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_HOLD, ST_GAP} state_t;

  localparam logic [7:0] DIV_LOAD     = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD     = 8'(GAP_CYCLES - 1);
  // A rejected command spends one extra cycle in GAP, standing in for the
  // LOW entry a legal command would have taken.
  localparam logic [7:0] GAP_LOAD_ILL = 8'(GAP_CYCLES);

  state_t      state_reg, state_next;
  logic [7:0]  phase_reg, phase_next;
  logic [6:0]  bit_reg, bit_next;
  logic        target_reg, target_next;
  logic [63:0] data_reg, data_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        reg_csb_reg, reg_csb_next;
  logic        vec_csb_reg, vec_csb_next;
  logic        sclk_reg, sclk_next;
  logic        mosi_reg, mosi_next;
  logic        phase_done;
  logic        cmd_accept;
  logic        in_frame;

  assign o_cmd_ready = (state_reg == ST_IDLE) && !i_abort && i_reset_n;
  assign cmd_accept  = i_cmd_valid && o_cmd_ready;
  assign phase_done  = (phase_reg == 8'd0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg   <= ST_IDLE;
      phase_reg   <= 8'd0;
      bit_reg     <= 7'd0;
      target_reg  <= 1'b0;
      data_reg    <= 64'd0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      reg_csb_reg <= 1'b1;
      vec_csb_reg <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_reg     <= bit_next;
      target_reg  <= target_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      reg_csb_reg <= reg_csb_next;
      vec_csb_reg <= vec_csb_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_done ? 8'd0 : phase_reg - 8'd1;
    bit_next    = bit_reg;
    target_next = target_reg;
    data_next   = data_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_accept) begin
          target_next = i_cmd_target;
          data_next   = i_cmd_data;
          if (i_cmd_nbits == 7'd0 || i_cmd_nbits > 7'd64) begin
            state_next = ST_GAP;
            phase_next = GAP_LOAD_ILL;
            err_next   = 1'b1;
          end else begin
            state_next = ST_LOW;
            phase_next = DIV_LOAD;
            bit_next   = i_cmd_nbits - 7'd1;
          end
        end
      end
      ST_LOW, ST_HIGH, ST_HOLD: begin
        if (i_abort) begin
          state_next = ST_GAP;
          phase_next = GAP_LOAD;
          err_next   = 1'b1;
        end else if (phase_done) begin
          phase_next = DIV_LOAD;
          if (state_reg == ST_LOW) begin
            state_next = ST_HIGH;
          end else if (state_reg == ST_HIGH) begin
            if (bit_reg != 7'd0) begin
              bit_next   = bit_reg - 7'd1;
              state_next = ST_LOW;
            end else begin
              state_next = ST_HOLD;
            end
          end else begin
            state_next = ST_GAP;
            phase_next = GAP_LOAD;
            done_next  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (phase_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Pins are registered from the next state so SCLK/CSB never glitch.
    in_frame     = (state_next == ST_LOW) || (state_next == ST_HIGH) || (state_next == ST_HOLD);
    reg_csb_next = !(in_frame && !target_next);
    vec_csb_next = !(in_frame && target_next);
    sclk_next    = (state_next == ST_HIGH);
    mosi_next    = ((state_next == ST_LOW) || (state_next == ST_HIGH)) ? data_next[bit_next[5:0]] : 1'b0;
  end

  assign o_reg_csb = reg_csb_reg;
  assign o_vec_csb = vec_csb_reg;
  assign o_sclk    = sclk_reg;
  assign o_mosi    = mosi_reg;
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_done    = done_reg;
  assign o_err     = err_reg;

endmodule

// File: tb/tb_rbz_spi_loader.sv
// Scoreboard bench for rbz_spi_loader: instance 0 uses defaults, instance 1
// uses CLK_DIV=1 for the 64-bit transfer.
module tb_rbz_spi_loader;

  typedef struct {
    bit          is_err;
    bit          tgt;
    int          low;
    int          nb;
    logic [63:0] bits;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid[2];
  logic        cmd_ready[2];
  logic        cmd_target[2];
  logic [6:0]  cmd_nbits[2];
  logic [63:0] cmd_data[2];
  logic        abort[2];
  logic        reg_csb[2];
  logic        vec_csb[2];
  logic        sclk[2];
  logic        mosi[2];
  logic        busy[2];
  logic        done[2];
  logic        err[2];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  exp_t        exp_q[2][$];
  int          rise_cyc[2];
  int          gap_meas[2];
  int          low_cnt[2];
  int          nb_seen[2];
  logic [63:0] bits_seen[2];
  logic        tgt_seen[2];
  logic        prev_sclk[2];
  logic        was_active[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    rbz_spi_loader #(.CLK_DIV(gi == 0 ? 2 : 1), .GAP_CYCLES(4)) u_dut (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_cmd_valid (cmd_valid[gi]),
      .o_cmd_ready (cmd_ready[gi]),
      .i_cmd_target(cmd_target[gi]),
      .i_cmd_nbits (cmd_nbits[gi]),
      .i_cmd_data  (cmd_data[gi]),
      .i_abort     (abort[gi]),
      .o_reg_csb   (reg_csb[gi]),
      .o_vec_csb   (vec_csb[gi]),
      .o_sclk      (sclk[gi]),
      .o_mosi      (mosi[gi]),
      .o_busy      (busy[gi]),
      .o_done      (done[gi]),
      .o_err       (err[gi])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pack(input int k);
    return {reg_csb[k], vec_csb[k], sclk[k], mosi[k], busy[k], done[k], err[k], cmd_ready[k]};
  endfunction

  task automatic push(input int k, input bit is_err, input bit tgt, input int low, input int nb,
                      input logic [63:0] bits);
    exp_t e;
    e.is_err = is_err; e.tgt = tgt; e.low = low; e.nb = nb; e.bits = bits;
    exp_q[k].push_back(e);
  endtask

  task automatic issue(input int k, input bit tgt, input logic [6:0] nb, input logic [63:0] d,
                       output int waited);
    cmd_target[k] = tgt; cmd_nbits[k] = nb; cmd_data[k] = d; cmd_valid[k] = 1'b1;
    waited = 0;
    #1;
    while (!cmd_ready[k] && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept", 64'(cmd_ready[k]), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((busy[k] || !cmd_ready[k]) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 64'(busy[k]), 64'd0);
  endtask

  // Monitor: rebuilds each CSB frame from the pins and retires it on done/err.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic act;
      exp_t e;
      if (!reset_n) begin
        low_cnt[k] = 0; nb_seen[k] = 0; bits_seen[k] = 64'd0;
        prev_sclk[k] = 1'b0; was_active[k] = 1'b0;
      end else begin
        act = !reg_csb[k] || !vec_csb[k];
        if (!reg_csb[k] && !vec_csb[k]) begin
          n_miss++;
          $display("FAIL csb_overlap dut%0d: both CSBs low at cycle %0d, required never", k, cyc);
        end
        if (done[k] && err[k]) begin
          n_miss++;
          $display("FAIL done_err_overlap dut%0d: both high at cycle %0d, required never", k, cyc);
        end
        if (act && !was_active[k]) begin
          gap_meas[k] = cyc - rise_cyc[k];
          tgt_seen[k] = !vec_csb[k];
        end
        if (!act && was_active[k]) rise_cyc[k] = cyc;
        if (act) low_cnt[k]++;
        if (sclk[k] && !prev_sclk[k]) begin
          bits_seen[k] = {bits_seen[k][62:0], mosi[k]};
          nb_seen[k]++;
        end
        if (done[k] || err[k]) begin
          if (exp_q[k].size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_end dut%0d: done=%0d err=%0d, required no completion", k, done[k], err[k]);
          end else begin
            e = exp_q[k].pop_front();
            check("end_kind", 64'(err[k]), 64'(e.is_err));
            if (e.low != 0) check("target", 64'(tgt_seen[k]), 64'(e.tgt));
            check("csb_low_cycles", 64'(low_cnt[k]), 64'(e.low));
            check("sclk_edges", 64'(nb_seen[k]), 64'(e.nb));
            check("sampled_bits", bits_seen[k], e.bits);
            $display("txn dut%0d %s tgt=%0d low=%0d edges=%0d bits=0x%0h", k, err[k] ? "err " : "done",
                     tgt_seen[k], low_cnt[k], nb_seen[k], bits_seen[k]);
          end
          low_cnt[k] = 0; nb_seen[k] = 0; bits_seen[k] = 64'd0;
        end
        prev_sclk[k]  = sclk[k];
        was_active[k] = act;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    logic [6:0] bad_nb[2];
    bad_nb[0] = 7'd0; bad_nb[1] = 7'd65;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_target[k] = 1'b0; cmd_nbits[k] = 7'd0;
      cmd_data[k] = 64'd0; abort[k] = 1'b0;
      rise_cyc[k] = 0; gap_meas[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs0", 64'(pack(0)), 64'hC0);
    check("reset_outputs1", 64'(pack(1)), 64'hC0);
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(cmd_ready[0]), 64'd1);

    // 8-bit 0xA5 to the register port
    push(0, 0, 0, 34, 8, 64'hA5);
    issue(0, 0, 7'd8, 64'hA5, w);
    cmd_valid[0] = 1'b0;
    n = 0;
    while (!cmd_ready[0] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_return_delay", 64'(cyc - rise_cyc[0]), 64'd4);

    // 64-bit at CLK_DIV=1 to the vector port
    push(1, 0, 1, 129, 64, 64'h8000_0000_0000_0001);
    issue(1, 1, 7'd64, 64'h8000_0000_0000_0001, w);
    cmd_valid[1] = 1'b0;
    wait_idle(1);

    // Illegal lengths
    for (int i = 0; i < 2; i++) begin
      push(0, 1, 0, 0, 0, 64'd0);
      issue(0, 0, bad_nb[i], 64'hFFFF, w);
      cmd_valid[0] = 1'b0;
      n = 0;
      while (busy[0] && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("illegal_busy_cycles", 64'(n), 64'd5);
      wait_idle(0);
    end

    // Abort during the third HIGH phase of a 16-bit transfer
    push(0, 1, 0, 11, 3, 64'h5);
    issue(0, 0, 7'd16, 64'hBEEF, w);
    cmd_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    abort[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_pins", 64'({reg_csb[0], vec_csb[0], sclk[0], err[0], done[0]}), 64'b11010);
    abort[0] = 1'b0;
    push(0, 0, 1, 22, 5, 64'h16);
    issue(0, 1, 7'd5, 64'h16, w);
    check("accept_after_abort_gap", 64'(w), 64'd4);
    cmd_valid[0] = 1'b0;
    wait_idle(0);

    // Back-to-back with valid held: reg then vec
    push(0, 0, 0, 18, 4, 64'h9);
    push(0, 0, 1, 14, 3, 64'h3);
    issue(0, 0, 7'd4, 64'h9, w);
    issue(0, 1, 7'd3, 64'h3, w);
    cmd_valid[0] = 1'b0;
    wait_idle(0);
    check("b2b_csb_gap", 64'(gap_meas[0]), 64'd5);

    // Reset pulse mid-transfer, then immediate new command
    issue(0, 1, 7'd8, 64'h3C, w);
    cmd_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_outputs", 64'(pack(0)), 64'hC0);
    reset_n = 1'b1;
    push(0, 0, 0, 10, 2, 64'h2);
    issue(0, 0, 7'd2, 64'h2, w);
    check("accept_after_reset", 64'(w), 64'd0);
    cmd_valid[0] = 1'b0;
    wait_idle(0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty0", 64'(exp_q[0].size()), 64'd0);
    check("queue_empty1", 64'(exp_q[1].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
